upower_decode_stage: RTL and testbench

- Instruction decode/issue stage directly upstream of the 64-bit uPower ALU.
- Buffers fetched 32-bit instruction words in a small FIFO and splits each word into ALU fields (opcode, rs/rt/ra/rb, bo, bi, si, ds, xox, xoxo, aa, xods).
- Classifies the instruction format, reads two register operands with writeback forwarding, and presents one decoded instruction per cycle to the ALU over a valid/ready handshake.

---
 rtl/upower_pkg.sv | 60 ++++++
 rtl/upower_instr_fifo.sv | 58 +++++
 rtl/upower_decode_stage.sv | 164 ++++++++++++++++
 tb/tb_upower_decode_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upower_pkg.sv
// Shared decode definitions for the uPower decode/issue stage.
// Holds the instruction format encodings, the opcode constants that drive
// format classification, the XO sub-opcodes and the store opcode set.
package upower_pkg;

  typedef enum logic [2:0] {
    FMT_XO  = 3'd0,
    FMT_X   = 3'd1,
    FMT_D   = 3'd2,
    FMT_DS  = 3'd3,
    FMT_B   = 3'd4,
    FMT_I   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [5:0] OP_XFORM = 6'd31;
  localparam logic [5:0] OP_B     = 6'd19;
  localparam logic [5:0] OP_I     = 6'd18;
  localparam logic [5:0] OP_DS_LD = 6'd58;
  localparam logic [5:0] OP_DS_ST = 6'd62;

  localparam logic [8:0] XO_ADD  = 9'd266;
  localparam logic [8:0] XO_SUBF = 9'd40;

  function automatic logic is_d_op(input logic [5:0] op);
    logic r;
    case (op)
      6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
      6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    logic r;
    case (op)
      6'd36, 6'd37, 6'd38, 6'd44, OP_DS_ST: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic fmt_e classify(input logic [5:0] op, input logic [8:0] xoxo);
    fmt_e f;
    f = FMT_ILL;
    if (op == OP_XFORM)
      f = (xoxo == XO_ADD || xoxo == XO_SUBF) ? FMT_XO : FMT_X;
    else if (is_d_op(op))
      f = FMT_D;
    else if (op == OP_DS_LD || op == OP_DS_ST)
      f = FMT_DS;
    else if (op == OP_B)
      f = FMT_B;
    else if (op == OP_I)
      f = FMT_I;
    return f;
  endfunction

endpackage

// File: rtl/upower_instr_fifo.sv
// Instruction word FIFO, DEPTH entries (power of 2).
// Ports: clk, rst_n (async active-low), flush (clears pointers/count),
//        push/wr_data, pop/rd_data (head word, valid when !empty), full, empty.
module upower_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  // Storage has no reset; only entries covered by count are ever read out.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of 2.
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/upower_decode_stage.sv
// Decode/issue stage feeding the 64-bit uPower ALU.
// Buffers fetched words, decodes the FIFO head combinationally (fields,
// format, register read addresses, forwarded operands, destination) and
// loads the result into an output register handed to the ALU by valid/ready.
// Ports: fetch side in_valid/in_instr/in_ready; flush; register file
//        rf_addr_a/b -> rf_data_a/b; writeback wb_en/wb_addr/wb_data;
//        ALU side out_valid/out_ready plus the decoded out_* fields.
module upower_decode_stage
  import upower_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  input  logic            flush,
  output logic [4:0]      rf_addr_a,
  output logic [4:0]      rf_addr_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_ra,
  output logic [4:0]      out_rb,
  output logic [15:0]     out_si,
  output logic [13:0]     out_ds,
  output logic [1:0]      out_xods,
  output logic [9:0]      out_xox,
  output logic [8:0]      out_xoxo,
  output logic            out_aa,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [4:0]      out_dest,
  output logic            out_wr_en,
  output logic            out_illegal
);

  logic [31:0] head;
  logic        fifo_full, fifo_empty;
  logic        push, pop;

  // A flush empties the FIFO this cycle, so fetch never sees backpressure
  // during a redirect even though the word offered alongside it is dropped.
  assign in_ready = !fifo_full || flush;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !fifo_empty && (!out_valid || out_ready) && !flush;

  upower_instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .wr_data (in_instr),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  logic [5:0]      h_op;
  logic [4:0]      h_rs, h_ra, h_rb;
  fmt_e            h_fmt;
  logic [XLEN-1:0] h_op_a, h_op_b;
  logic [4:0]      h_dest;
  logic            h_wr_en;

  assign h_op = head[31:26];
  assign h_rs = head[25:21];
  assign h_ra = head[20:16];
  assign h_rb = head[15:11];

  always_comb h_fmt = classify(h_op, head[9:1]);

  assign rf_addr_a = h_ra;
  assign rf_addr_b = (h_fmt == FMT_XO || h_fmt == FMT_X) ? h_rb : h_rs;

  // Writeback forwarding covers the write landing in the same cycle the
  // register file is read; register 0 gets no special treatment.
  always_comb begin
    h_op_a = (wb_en && wb_addr == rf_addr_a) ? wb_data : rf_data_a;
    h_op_b = (wb_en && wb_addr == rf_addr_b) ? wb_data : rf_data_b;
    if (h_fmt == FMT_I) begin
      h_op_a = '0;
      h_op_b = '0;
    end
  end

  always_comb begin
    h_dest  = '0;
    h_wr_en = 1'b0;
    case (h_fmt)
      FMT_XO: begin
        h_dest  = h_rs;
        h_wr_en = 1'b1;
      end
      FMT_X: begin
        h_dest  = h_ra;
        h_wr_en = 1'b1;
      end
      FMT_D, FMT_DS: begin
        h_dest  = h_rs;
        h_wr_en = !is_store(h_op);
      end
      default: begin
        h_dest  = '0;
        h_wr_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_rs      <= '0;
      out_ra      <= '0;
      out_rb      <= '0;
      out_si      <= '0;
      out_ds      <= '0;
      out_xods    <= '0;
      out_xox     <= '0;
      out_xoxo    <= '0;
      out_aa      <= 1'b0;
      out_fmt     <= '0;
      out_op_a    <= '0;
      out_op_b    <= '0;
      out_dest    <= '0;
      out_wr_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_opcode  <= h_op;
      out_rs      <= h_rs;
      out_ra      <= h_ra;
      out_rb      <= h_rb;
      out_si      <= head[15:0];
      out_ds      <= head[15:2];
      out_xods    <= head[1:0];
      out_xox     <= head[10:1];
      out_xoxo    <= head[9:1];
      out_aa      <= head[1];
      out_fmt     <= h_fmt;
      out_op_a    <= h_op_a;
      out_op_b    <= h_op_b;
      out_dest    <= h_dest;
      out_wr_en   <= h_wr_en;
      out_illegal <= (h_fmt == FMT_ILL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upower_decode_stage.sv
module tb_upower_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [63:0] rf_data_a, rf_data_b;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        out_valid, out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs, out_ra, out_rb;
  logic [15:0] out_si;
  logic [13:0] out_ds;
  logic [1:0]  out_xods;
  logic [9:0]  out_xox;
  logic [8:0]  out_xoxo;
  logic        out_aa;
  logic [2:0]  out_fmt;
  logic [63:0] out_op_a, out_op_b;
  logic [4:0]  out_dest;
  logic        out_wr_en, out_illegal;

  always #5 clk = ~clk;

  logic [63:0] rf [32];
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  upower_decode_stage #(.DEPTH(4), .XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .rf_addr_a(rf_addr_a),
    .rf_addr_b(rf_addr_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rs(out_rs), .out_ra(out_ra), .out_rb(out_rb), .out_si(out_si),
    .out_ds(out_ds), .out_xods(out_xods), .out_xox(out_xox),
    .out_xoxo(out_xoxo), .out_aa(out_aa), .out_fmt(out_fmt),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_dest(out_dest),
    .out_wr_en(out_wr_en), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] w;
    logic        fa;
    logic [63:0] va;
  } item_t;

  item_t mq[$];
  int    nvec = 0;
  int    nerr = 0;
  int    pushes = 0;
  int    deqs = 0;
  int    d_ops[13] = '{14, 15, 24, 26, 28, 32, 34, 36, 37, 38, 40, 42, 44};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_fmt(input logic [31:0] w);
    int op = int'(w[31:26]);
    int xo = int'(w[9:1]);
    if (op == 31) return (xo == 266 || xo == 40) ? 0 : 1;
    if (op inside {14, 15, 24, 26, 28, 32, 34, 36, 37, 38, 40, 42, 44}) return 2;
    if (op == 58 || op == 62) return 3;
    if (op == 19) return 4;
    if (op == 18) return 5;
    return 7;
  endfunction

  task automatic compare_item(input item_t e);
    logic [31:0] w;
    int f, op, rs, ra, rb, dest, wr;
    logic [63:0] ea, eb;
    w  = e.w;
    f  = ref_fmt(w);
    op = int'(w[31:26]);
    rs = int'(w[25:21]);
    ra = int'(w[20:16]);
    rb = int'(w[15:11]);
    chk("fields_hi", 64'({out_opcode, out_rs, out_ra, out_rb}), 64'(w[31:11]));
    chk("fields_lo", 64'({out_si, out_ds, out_xods, out_xox, out_xoxo, out_aa}),
        64'({w[15:0], w[15:2], w[1:0], w[10:1], w[9:1], w[1]}));
    chk("fmt", 64'(out_fmt), 64'(f));
    chk("illegal", 64'(out_illegal), 64'(f == 7));
    dest = (f == 0 || f == 2 || f == 3) ? rs : (f == 1) ? ra : 0;
    wr   = (f == 0 || f == 1) ? 1 :
           ((f == 2 || f == 3) && !(op inside {36, 37, 38, 44, 62})) ? 1 : 0;
    chk("dest", 64'(out_dest), 64'(dest));
    chk("wr_en", 64'(out_wr_en), 64'(wr));
    if (f != 7) begin
      ea = (f == 5) ? 64'd0 : (e.fa ? e.va : rf[ra]);
      eb = (f == 5) ? 64'd0 : (f <= 1) ? rf[rb] : rf[rs];
      chk("op_a", out_op_a, ea);
      chk("op_b", out_op_b, eb);
    end
  endtask

  // One clock: observe the cycle's handshakes mid-cycle, then advance to the
  // next falling edge where the caller drives new inputs.
  task automatic tick();
    item_t e;
    #1;
    if (out_valid) chk("stale_valid", 64'(mq.size() != 0), 64'd1);
    if (flush) begin
      mq.delete();
    end else begin
      if (out_valid && out_ready && mq.size() != 0) begin
        e = mq.pop_front();
        compare_item(e);
        deqs++;
      end
      if (in_valid && in_ready) begin
        e.w = in_instr; e.fa = 1'b0; e.va = '0;
        mq.push_back(e);
        pushes++;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int pick;
    w    = $urandom;
    pick = $urandom_range(0, 9);
    if (pick <= 1) begin
      w[31:26] = 6'd31;
      case ($urandom_range(0, 2))
        0: w[9:1] = 9'd266;
        1: w[9:1] = 9'd40;
        default: ;
      endcase
    end else if (pick <= 5) w[31:26] = 6'(d_ops[$urandom_range(0, 12)]);
    else if (pick == 6) w[31:26] = ($urandom_range(0, 1) != 0) ? 6'd58 : 6'd62;
    else if (pick == 7) w[31:26] = 6'd19;
    else if (pick == 8) w[31:26] = 6'd18;
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int base, cyc, d0;
    item_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};

    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fields", 64'({out_fmt, out_dest, out_wr_en, out_illegal, out_opcode}), 64'd0);
    chk("rst_op_a", out_op_a, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // XO add with two-cycle latency
    rf[4] = 64'd7; rf[5] = 64'd9;
    in_valid = 1'b1; in_instr = 32'h7C642A14;
    tick();
    in_valid = 1'b0;
    chk("xo_lat_n1", 64'(out_valid), 64'd0);
    tick();
    chk("xo_lat_n2", 64'(out_valid), 64'd1);
    chk("xo_fmt", 64'(out_fmt), 64'd0);
    chk("xo_op_a", out_op_a, 64'd7);
    chk("xo_op_b", out_op_b, 64'd9);
    chk("xo_dest", 64'(out_dest), 64'd3);
    chk("xo_wr_en", 64'(out_wr_en), 64'd1);
    tick();

    // Backpressure: 4 buffered + 1 held
    out_ready = 1'b0; base = pushes;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_instr = rand_word();
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(pushes - base), 64'd5);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1; d0 = deqs; cyc = 0;
    while (deqs - d0 < 5 && cyc < 20) begin tick(); cyc++; end
    chk("bp_drained", 64'(deqs - d0), 64'd5);
    chk("bp_throughput", 64'(cyc), 64'd5);

    // Forwarding in the load cycle
    in_valid = 1'b1; in_instr = {6'd14, 5'd6, 5'd4, 16'h0010};
    tick();
    e = mq.pop_back(); e.fa = 1'b1; e.va = 64'hDEAD; mq.push_back(e);
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'hDEAD;
    tick();
    wb_en = 1'b0;
    chk("fwd_valid", 64'(out_valid), 64'd1);
    chk("fwd_op_a", out_op_a, 64'hDEAD);

    // Store: operand B read from RS
    in_valid = 1'b1; in_instr = {6'd36, 5'd9, 5'd2, 16'h0008};
    tick();
    in_valid = 1'b0;
    chk("st_addr_b", 64'(rf_addr_b), 64'd9);
    chk("st_addr_a", 64'(rf_addr_a), 64'd2);
    tick();
    chk("st_fmt", 64'(out_fmt), 64'd2);
    chk("st_wr_en", 64'(out_wr_en), 64'd0);

    // Illegal opcode
    in_valid = 1'b1; in_instr = {6'h3F, 26'h0ABCDEF};
    tick();
    in_valid = 1'b0;
    tick();
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_fmt", 64'(out_fmt), 64'd7);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_wr_en", 64'(out_wr_en), 64'd0);
    tick();

    // Flush with 3 buffered + 1 held + concurrent push
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_instr = rand_word();
      tick();
    end
    chk("fl_held", 64'(out_valid), 64'd1);
    flush = 1'b1; in_instr = rand_word();
    #1 chk("fl_in_ready_during", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("fl_no_stale", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0; base = pushes;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_instr = rand_word();
      tick();
    end
    in_valid = 1'b0;
    chk("fl_count_clear", 64'(pushes - base), 64'd5);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();

    // Randomized traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_word();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("rand_all_drained", 64'(mq.size()), 64'd0);

    // Async reset while stalled
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_instr = rand_word();
      tick();
    end
    in_valid = 1'b0;
    chk("ar_held", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_opcode", 64'(out_opcode), 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("ar_lost", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
